// File: rtl/serial_fifo_param.sv
// rtl/serial_fifo_param.sv - parametrised single-clock FIFO with occupancy, sticky flags, high-water mark and threshold irq
//
// Optional feature macro: SERIAL_FIFO_THRESH_IRQ_EN (threshold/overflow interrupt; irq tied low when undefined)
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   wr_data, wr_request             push data and single-cycle push request
//   rd_request                      single-cycle pop request
//   flush                           synchronous empty (storage contents kept)
//   clear_overflow_request          clears sticky overflow
//   clear_underflow_request         clears sticky underflow
//   clear_watermark_request         reloads watermark with next occupancy
//   thresh, irq_enable              interrupt level (0 disables level term) and enable
//   rd_data                         registered popped word
//   empty, full, count              occupancy status
//   overflow, underflow             sticky error flags
//   wr_index, rd_index              storage pointers
//   watermark                       highest occupancy since last clear
//   irq                             interrupt
module serial_fifo_param #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_request,
  input  logic                  rd_request,
  input  logic                  flush,
  input  logic                  clear_overflow_request,
  input  logic                  clear_underflow_request,
  input  logic                  clear_watermark_request,
  input  logic [ADDR_WIDTH:0]   thresh,
  input  logic                  irq_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] wr_index,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic [ADDR_WIDTH:0]   watermark,
  output logic                  irq
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  push_ok;
  logic                  pop_ok;
  logic                  overflow_set;
  logic                  underflow_set;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH-1:0] wr_index_next;
  logic [ADDR_WIDTH-1:0] rd_index_next;
  logic                  overflow_next;
  logic                  underflow_next;
  logic [ADDR_WIDTH:0]   watermark_next;
  logic                  irq_next;

  // count never exceeds DEPTH = 2^ADDR_WIDTH, so its top bit alone marks full
  assign empty = (count == '0);
  assign full  = count[ADDR_WIDTH];

  always_comb begin
    push_ok        = 1'b0;
    pop_ok         = 1'b0;
    overflow_set   = 1'b0;
    underflow_set  = 1'b0;
    count_next     = count;
    wr_index_next  = wr_index;
    rd_index_next  = rd_index;
    overflow_next  = overflow;
    underflow_next = underflow;
    watermark_next = watermark;
    irq_next       = 1'b0;

    // flush swallows same-cycle requests entirely, including their error flags
    if (!flush) begin
      // a pop on a full FIFO frees the slot the simultaneous push lands in
      push_ok       = wr_request && (!full || rd_request);
      pop_ok        = rd_request && !empty;
      overflow_set  = wr_request && full && !rd_request;
      underflow_set = rd_request && empty;
    end

    if (flush) begin
      count_next    = '0;
      wr_index_next = '0;
      rd_index_next = '0;
    end else begin
      if (push_ok) wr_index_next = wr_index + IDX_ONE;
      if (pop_ok)  rd_index_next = rd_index + IDX_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end

    // a new error event outranks a clear arriving in the same cycle
    if (overflow_set)                 overflow_next = 1'b1;
    else if (clear_overflow_request)  overflow_next = 1'b0;
    if (underflow_set)                underflow_next = 1'b1;
    else if (clear_underflow_request) underflow_next = 1'b0;

    if (clear_watermark_request)      watermark_next = count_next;
    else if (count_next > watermark)  watermark_next = count_next;

`ifdef SERIAL_FIFO_THRESH_IRQ_EN
    irq_next = irq_enable && (((thresh != '0) && (count_next >= thresh)) || overflow_next);
`endif
  end

`ifndef SERIAL_FIFO_THRESH_IRQ_EN
  logic unused_irq_cfg;
  assign unused_irq_cfg = ^{thresh, irq_enable};
`endif

  // storage is deliberately left out of reset and flush
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_index] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      count     <= '0;
      wr_index  <= '0;
      rd_index  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      watermark <= '0;
      irq       <= 1'b0;
    end else begin
      // reads the pre-edge entry, so a full push+pop returns the oldest word
      if (pop_ok) rd_data <= mem[rd_index];
      count     <= count_next;
      wr_index  <= wr_index_next;
      rd_index  <= rd_index_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      watermark <= watermark_next;
      irq       <= irq_next;
    end
  end

endmodule

// File: tb/tb_serial_fifo_param.sv
// tb/tb_serial_fifo_param.sv - scoreboard testbench for serial_fifo_param
module tb_serial_fifo_param;

  localparam int DW    = 9;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef SERIAL_FIFO_THRESH_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wr_data;
  logic          wr_request, rd_request, flush;
  logic          clear_overflow_request, clear_underflow_request, clear_watermark_request;
  logic [AW:0]   thresh;
  logic          irq_enable;
  logic [DW-1:0] rd_data;
  logic          empty, full, overflow, underflow, irq;
  logic [AW:0]   count, watermark;
  logic [AW-1:0] wr_index, rd_index;

  serial_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_request(wr_request),
    .rd_request(rd_request), .flush(flush),
    .clear_overflow_request(clear_overflow_request),
    .clear_underflow_request(clear_underflow_request),
    .clear_watermark_request(clear_watermark_request),
    .thresh(thresh), .irq_enable(irq_enable), .rd_data(rd_data),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .count(count), .wr_index(wr_index), .rd_index(rd_index),
    .watermark(watermark), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: a plain queue of stored words plus expected register values
  logic [DW-1:0] q[$];
  int            m_wr, m_rd, m_wm;
  bit            m_ovf, m_unf, m_irq;
  logic [DW-1:0] m_rd_data;

  task automatic model_reset();
    q.delete();
    m_wr = 0; m_rd = 0; m_wm = 0;
    m_ovf = 0; m_unf = 0; m_irq = 0;
    m_rd_data = '0;
  endtask

  task automatic model_step();
    int cnt;
    bit full_m, empty_m, push_ok, pop_ok, ovf_set, unf_set;
    cnt = q.size();
    full_m  = (cnt == DEPTH);
    empty_m = (cnt == 0);
    push_ok = 0; pop_ok = 0; ovf_set = 0; unf_set = 0;
    if (!flush) begin
      pop_ok  = rd_request && !empty_m;
      push_ok = wr_request && (!full_m || rd_request);
      ovf_set = wr_request && full_m && !rd_request;
      unf_set = rd_request && empty_m;
    end
    if (pop_ok) begin
      m_rd_data = q.pop_front();
      m_rd = (m_rd + 1) % DEPTH;
    end
    if (push_ok) begin
      q.push_back(wr_data);
      m_wr = (m_wr + 1) % DEPTH;
    end
    if (flush) begin
      q.delete();
      m_wr = 0; m_rd = 0;
    end
    cnt = q.size();
    if (ovf_set) m_ovf = 1; else if (clear_overflow_request) m_ovf = 0;
    if (unf_set) m_unf = 1; else if (clear_underflow_request) m_unf = 0;
    if (clear_watermark_request) m_wm = cnt;
    else if (cnt > m_wm)         m_wm = cnt;
    m_irq = IRQ_ON && irq_enable && (((thresh != 0) && (cnt >= int'(thresh))) || m_ovf);
  endtask

  task automatic compare_all();
    int cnt;
    cnt = q.size();
    check_eq("count",     count,     cnt);
    check_eq("empty",     empty,     cnt == 0);
    check_eq("full",      full,      cnt == DEPTH);
    check_eq("wr_index",  wr_index,  m_wr);
    check_eq("rd_index",  rd_index,  m_rd);
    check_eq("overflow",  overflow,  m_ovf);
    check_eq("underflow", underflow, m_unf);
    check_eq("watermark", watermark, m_wm);
    check_eq("rd_data",   rd_data,   m_rd_data);
    check_eq("irq",       irq,       m_irq);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    wr_request = 0; rd_request = 0; flush = 0;
    clear_overflow_request = 0; clear_underflow_request = 0; clear_watermark_request = 0;
    compare_all();
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_data = d; wr_request = 1; tick();
  endtask

  task automatic pop();
    rd_request = 1; tick();
  endtask

  initial begin
    reset = 1; wr_data = '0; wr_request = 0; rd_request = 0; flush = 0;
    clear_overflow_request = 0; clear_underflow_request = 0; clear_watermark_request = 0;
    thresh = 5'd4; irq_enable = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty", empty, 1);
    check_eq("rst_count", count, 0);
    compare_all();
    reset = 0;

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push(9'h101 + 9'(i));
    check_eq("fill_count", count, 16);
    check_eq("fill_full", full, 1);
    check_eq("fill_wr_index", wr_index, 0);
    check_eq("fill_watermark", watermark, 16);
    push(9'h1FF);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      pop();
      check_eq("drain_data", rd_data, 9'h101 + 9'(i));
    end
    check_eq("drain_empty", empty, 1);
    clear_overflow_request = 1; tick();

    // underflow, clear priority
    pop();
    check_eq("unf_flag", underflow, 1);
    check_eq("unf_rd_data_hold", rd_data, 9'h110);
    rd_request = 1; clear_underflow_request = 1; tick();
    check_eq("unf_set_beats_clear", underflow, 1);
    clear_underflow_request = 1; tick();
    check_eq("unf_clear", underflow, 0);

    // full push+pop is read-before-write
    for (int i = 0; i < 16; i++) push(9'h020 + 9'(i));
    wr_data = 9'h0AA; wr_request = 1; rd_request = 1; tick();
    check_eq("fullrw_data", rd_data, 9'h020);
    check_eq("fullrw_count", count, 16);
    check_eq("fullrw_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) pop();
    check_eq("fullrw_last", rd_data, 9'h0AA);

    // empty push+pop: push taken, pop rejected
    wr_data = 9'h033; wr_request = 1; rd_request = 1; tick();
    check_eq("emptyrw_count", count, 1);
    check_eq("emptyrw_unf", underflow, 1);
    pop();
    clear_underflow_request = 1; clear_watermark_request = 1; tick();
    check_eq("wm_clear0", watermark, 0);

    // pointer wrap, watermark follows peak occupancy
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) push(9'($urandom_range(0, 511)));
      for (int i = 0; i < 5; i++) pop();
    end
    check_eq("wrap_wm", watermark, 5);
    clear_watermark_request = 1; tick();
    check_eq("wrap_wm_clear", watermark, 0);

    // threshold interrupt and flush
    thresh = 5'd4; irq_enable = 1;
    for (int i = 0; i < 3; i++) push(9'h040 + 9'(i));
    check_eq("irq_below", irq, 0);
    push(9'h043);
    check_eq("irq_at_thresh", irq, IRQ_ON);
    wr_data = 9'h1AB; wr_request = 1; rd_request = 1; flush = 1; tick();
    check_eq("flush_count", count, 0);
    check_eq("flush_irq", irq, 0);
    check_eq("flush_unf", underflow, 0);
    check_eq("flush_wm", watermark, 4);
    irq_enable = 0;
    for (int i = 0; i < 17; i++) push(9'h050 + 9'(i));
    flush = 1; tick();
    check_eq("flush_keeps_ovf", overflow, 1);
    clear_overflow_request = 1; irq_enable = 1; tick();

    // asynchronous reset mid-operation with a push pending
    for (int i = 0; i < 7; i++) push(9'h060 + 9'(i));
    wr_data = 9'h0EE; wr_request = 1;
    #2 reset = 1;
    #1;
    model_reset();
    check_eq("arst_count", count, 0);
    check_eq("arst_empty", empty, 1);
    check_eq("arst_wr_index", wr_index, 0);
    compare_all();
    @(posedge clk);
    #1;
    wr_request = 0;
    reset = 0;
    compare_all();
    push(9'h077);
    check_eq("post_rst_wr_index", wr_index, 1);
    pop();
    check_eq("post_rst_data", rd_data, 9'h077);

    // random traffic against the model
    for (int c = 0; c < 300; c++) begin
      wr_data    = 9'($urandom_range(0, 511));
      wr_request = ($urandom_range(0, 99) < 55);
      rd_request = ($urandom_range(0, 99) < 45);
      flush      = ($urandom_range(0, 99) < 3);
      clear_overflow_request  = ($urandom_range(0, 99) < 8);
      clear_underflow_request = ($urandom_range(0, 99) < 8);
      clear_watermark_request = ($urandom_range(0, 99) < 5);
      if (c % 50 == 0) begin
        thresh     = 5'($urandom_range(0, 16));
        irq_enable = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
